// File: rtl/polar_a_rect_pkg.sv
// Shared types and constants for the polar-to-rectangular converter.
// SIN_TAB holds round(16384*sin(i deg)) for i = 0..90 (unsigned Q1.14).
package polar_pkg;
  typedef enum logic [2:0] {IDLE, RDSIN, RDCOS, LATCH, MUL, FIN} state_e;

  localparam int Q_FRAC    = 14;
  localparam int COEF_W    = 15;
  localparam int TAB_DEPTH = 91;
  localparam int ANG_MAX   = 180;

  localparam logic [COEF_W-1:0] SIN_TAB [TAB_DEPTH] = '{
    15'd0,     15'd286,   15'd572,   15'd857,   15'd1143,  15'd1428,  15'd1713,
    15'd1997,  15'd2280,  15'd2563,  15'd2845,  15'd3126,  15'd3406,  15'd3686,
    15'd3964,  15'd4240,  15'd4516,  15'd4790,  15'd5063,  15'd5334,  15'd5604,
    15'd5872,  15'd6138,  15'd6402,  15'd6664,  15'd6924,  15'd7182,  15'd7438,
    15'd7692,  15'd7943,  15'd8192,  15'd8438,  15'd8682,  15'd8923,  15'd9162,
    15'd9397,  15'd9630,  15'd9860,  15'd10087, 15'd10311, 15'd10531, 15'd10749,
    15'd10963, 15'd11174, 15'd11381, 15'd11585, 15'd11786, 15'd11982, 15'd12176,
    15'd12365, 15'd12551, 15'd12733, 15'd12911, 15'd13085, 15'd13255, 15'd13421,
    15'd13583, 15'd13741, 15'd13894, 15'd14044, 15'd14189, 15'd14330, 15'd14466,
    15'd14598, 15'd14726, 15'd14849, 15'd14968, 15'd15082, 15'd15191, 15'd15296,
    15'd15396, 15'd15491, 15'd15582, 15'd15668, 15'd15749, 15'd15826, 15'd15897,
    15'd15964, 15'd16026, 15'd16083, 15'd16135, 15'd16182, 15'd16225, 15'd16262,
    15'd16294, 15'd16322, 15'd16344, 15'd16362, 15'd16374, 15'd16382, 15'd16384
  };
endpackage

// File: rtl/polar_a_rect_if.sv
// Start/Done request bus of the polar-to-rectangular converter.
interface polar_a_rect_if #(parameter int tamanyo = 32) ();
  logic               Start;
  logic [tamanyo-1:0] Mag;
  logic [31:0]        Angle;
  logic [tamanyo-1:0] X;
  logic [tamanyo-1:0] Y;
  logic               Err;
  logic               Done;

  modport master (output Start, Mag, Angle, input X, Y, Err, Done);
  modport slave  (input Start, Mag, Angle, output X, Y, Err, Done);
endinterface

// File: rtl/polar_a_rect_seno_rom.sv
// Quarter-wave sine ROM, 91 x 15, registered output (1-cycle read latency).
module seno_rom
  import polar_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTa,
  input  logic [6:0]        addr_i,
  output logic [COEF_W-1:0] q_o
);
  logic [COEF_W-1:0] q_q;

  always_ff @(posedge CLK or negedge RSTa)
    if (!RSTa)                           q_q <= '0;
    else if (addr_i < 7'(TAB_DEPTH))     q_q <= SIN_TAB[addr_i];
    else                                 q_q <= '0;

  assign q_o = q_q;
endmodule

// File: rtl/polar_a_rect.sv
// Polar-to-rectangular converter: X = Mag*cos(Angle), Y = Mag*sin(Angle),
// via quarter-wave ROM lookup and two parallel 15-step LSB-first shift-add multipliers.
module polar_a_rect
  import polar_pkg::*;
#(
  parameter int tamanyo = 32
) (
  input  logic          CLK,
  input  logic          RSTa,
  polar_a_rect_if.slave bus
);
  localparam int ACC_W = tamanyo + COEF_W;

  state_e             state_q, state_d;
  logic [tamanyo-1:0] mag_q;
  logic [6:0]         sidx_q, cidx_q, sidx_d, cidx_d, rom_addr;
  logic               sx_q, sy_q, angerr_q;
  logic [COEF_W-1:0]  csin_q, ccos_q, rom_q;
  logic [ACC_W-1:0]   mshift_q, accx_q, accy_q, accx_d, accy_d;
  logic [3:0]         cnt_q;
  logic [tamanyo-1:0] x_q, y_q, magx, magy, resx, resy;
  logic               err_q, wr_q, done_q;
  logic               ang_err, big;
  logic [7:0]         b;

  seno_rom u_rom (.CLK(CLK), .RSTa(RSTa), .addr_i(rom_addr), .q_o(rom_q));

  // Low byte suffices for |Angle| once the range check passes (-180 -> 0x4C -> 180).
  always_comb begin
    ang_err = ($signed(bus.Angle) > ANG_MAX) || ($signed(bus.Angle) < -ANG_MAX);
    b       = bus.Angle[31] ? 8'd0 - bus.Angle[7:0] : bus.Angle[7:0];
    big     = b > 8'd90;
    sidx_d  = big ? 7'(8'd180 - b) : b[6:0];
    cidx_d  = big ? 7'(b - 8'd90)  : 7'(8'd90 - b);
    if (ang_err) begin
      sidx_d = '0;
      cidx_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTa)
    if (!RSTa) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    rom_addr = '0;
    unique case (state_q)
      IDLE:  if (bus.Start) state_d = RDSIN;
      RDSIN: begin rom_addr = sidx_q; state_d = RDCOS; end
      RDCOS: begin rom_addr = cidx_q; state_d = LATCH; end
      LATCH: state_d = MUL;
      MUL:   if (cnt_q == 4'd0) state_d = FIN;
      FIN:   if (!bus.Start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Truncating the magnitude before negation gives symmetric rounding toward zero.
  always_comb begin
    accx_d = accx_q + (ccos_q[0] ? mshift_q : '0);
    accy_d = accy_q + (csin_q[0] ? mshift_q : '0);
    magx   = tamanyo'(accx_d >> Q_FRAC);
    magy   = tamanyo'(accy_d >> Q_FRAC);
    resx   = angerr_q ? '0 : (sx_q ? -magx : magx);
    resy   = angerr_q ? '0 : (sy_q ? -magy : magy);
  end

  always_ff @(posedge CLK or negedge RSTa)
    if (!RSTa) begin
      mag_q    <= '0;
      sidx_q   <= '0;
      cidx_q   <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      angerr_q <= 1'b0;
      csin_q   <= '0;
      ccos_q   <= '0;
      mshift_q <= '0;
      accx_q   <= '0;
      accy_q   <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_q   <= (state_q == MUL) && (cnt_q == 4'd0);
      done_q <= wr_q;
      unique case (state_q)
        IDLE: if (bus.Start) begin
          mag_q    <= bus.Mag;
          sidx_q   <= sidx_d;
          cidx_q   <= cidx_d;
          sx_q     <= big & ~ang_err;
          sy_q     <= bus.Angle[31] & ~ang_err;
          angerr_q <= ang_err;
        end
        RDCOS: csin_q <= rom_q;
        LATCH: begin
          ccos_q   <= rom_q;
          accx_q   <= '0;
          accy_q   <= '0;
          mshift_q <= ACC_W'(mag_q);
          cnt_q    <= 4'd14;
        end
        MUL: begin
          accx_q   <= accx_d;
          accy_q   <= accy_d;
          mshift_q <= mshift_q << 1;
          csin_q   <= csin_q >> 1;
          ccos_q   <= ccos_q >> 1;
          cnt_q    <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            x_q   <= resx;
            y_q   <= resy;
            err_q <= angerr_q;
          end
        end
        default: ;
      endcase
    end

  assign bus.X    = x_q;
  assign bus.Y    = y_q;
  assign bus.Err  = err_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_polar_a_rect.sv
// Scoreboard bench for polar_a_rect: reference built from real-valued sin/cos.
module tb_polar_a_rect;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RSTa = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   dones = 0;

  polar_a_rect_if #(.tamanyo(W)) bus ();
  polar_a_rect #(.tamanyo(W)) dut (.CLK(CLK), .RSTa(RSTa), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         err;
    int           k;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  function automatic logic [W-1:0] axis(input longint mag, input real v);
    longint q, p;
    q = longint'($floor(16384.0 * (v < 0.0 ? -v : v) + 0.5));
    p = (mag * q) >>> 14;
    return (v < 0.0) ? W'(-p) : W'(p);
  endfunction

  function automatic exp_t model(input logic [W-1:0] mag, input int ang);
    exp_t e;
    real  r;
    e.k = 0;
    if (ang > 180 || ang < -180) begin
      e.x = '0; e.y = '0; e.err = 1'b1;
    end else begin
      r = real'(ang) * 3.14159265358979323846 / 180.0;
      e.x = axis(longint'(mag), $cos(r));
      e.y = axis(longint'(mag), $sin(r));
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every Done must match the oldest outstanding request.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (RSTa && bus.Done) begin
      dones++;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("X", longint'($signed(bus.X)), longint'($signed(e.x)));
        chk("Y", longint'($signed(bus.Y)), longint'($signed(e.y)));
        chk("Err", longint'(bus.Err), longint'(e.err));
        chk("latency", longint'(cyc - e.k), 19);
      end
    end
  end

  task automatic run(input logic [W-1:0] mag, input int ang, input int hold);
    exp_t e;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Mag = mag; bus.Angle = ang;
    @(posedge CLK); #1;
    e = model(mag, ang);
    e.k = cyc;
    sbq.push_back(e);
    bus.Mag = $urandom & 32'h7fff_ffff;
    bus.Angle = $urandom;
    repeat (hold) @(posedge CLK);
    #1 bus.Start = 1'b0;
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge CLK);
    if (sbq.size() != 0) begin
      chk("timeout", longint'(sbq.size()), 0);
      sbq.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    int d0;
    bus.Start = 1'b0; bus.Mag = '0; bus.Angle = '0;
    repeat (3) @(negedge CLK);
    chk("rst_X", longint'(bus.X), 0);
    chk("rst_Y", longint'(bus.Y), 0);
    chk("rst_Err", longint'(bus.Err), 0);
    chk("rst_Done", longint'(bus.Done), 0);
    RSTa = 1'b1;
    repeat (2) @(negedge CLK);

    run(1000, 0, 0);
    run(1000, 90, 0);
    run(1000, -90, 1);
    run(1000, 180, 0);
    run(1000, -180, 0);
    run(1000, -135, 2);
    run(32'h7fff_ffff, 90, 0);
    run(32'h7fff_ffff, -45, 0);
    run(1000, 200, 0);
    run(1000, 181, 0);
    run(12345, -181, 0);
    run(777, 32'h8000_0000, 0);

    // Level Start held long: only one conversion, then a fresh one after release.
    d0 = dones;
    run(1000, 30, 40);
    chk("held_start_dones", longint'(dones - d0), 1);
    run(1000, 60, 0);

    // Reset during MUL clears outputs at once and drops the pending result.
    run(1000, 45, 0);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Mag = 5000; bus.Angle = 10;
    @(posedge CLK); #1 bus.Start = 1'b0;
    repeat (8) @(negedge CLK);
    RSTa = 1'b0;
    #1;
    chk("mid_rst_X", longint'(bus.X), 0);
    chk("mid_rst_Y", longint'(bus.Y), 0);
    chk("mid_rst_Err", longint'(bus.Err), 0);
    chk("mid_rst_Done", longint'(bus.Done), 0);
    repeat (2) @(negedge CLK);
    RSTa = 1'b1;
    d0 = dones;
    repeat (30) @(negedge CLK);
    chk("post_rst_no_done", longint'(dones - d0), 0);
    run(1000, 45, 0);

    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] m;
      int a;
      m = (n % 3 == 0) ? W'($urandom_range(0, 5000)) : ($urandom & 32'h7fff_ffff);
      a = int'($urandom_range(0, 420)) - 210;
      run(m, a, int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge CLK);
    if (sbq.size() != 0) chk("leftover", longint'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
